ab_input_conditioner: RTL and testbench

Two-channel input conditioner that sits directly upstream of the two-input AND stage and drives its `a` and `b` operands. Each asynchronous raw input passes through a 2-flop synchronizer and a per-channel debounce state machine. The block also emits clean rise/fall pulses, a both-stable flag, and saturating glitch counters for diagnostics. All logic runs in one clock domain.

---
 rtl/ab_input_conditioner.sv | 132 +++++++++++++
 tb/tb_ab_input_conditioner.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ab_input_conditioner.sv
// Purpose: two-channel synchronizer + debounce FSM driving the AND stage's a/b operands, with edge pulses and glitch counters.
// Latency: a raw level held from edge E0 appears on a/b after edge E(STABLE_CNT+1); pulses follow the level change.
// Backpressure: none; the block free-runs every clock and never stalls its inputs.
module ab_input_conditioner #(
    parameter int STABLE_CNT = 4,
    parameter int CNT_W      = 4,
    parameter int GLITCH_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                raw_a,
    input  logic                raw_b,
    output logic                a,
    output logic                b,
    output logic                a_rise,
    output logic                a_fall,
    output logic                b_rise,
    output logic                b_fall,
    output logic                ab_stable,
    output logic [GLITCH_W-1:0] a_glitches,
    output logic [GLITCH_W-1:0] b_glitches
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    logic [1:0]          raw;
    logic [1:0]          s1;
    logic [1:0]          s2;
    state_t              st     [2];
    logic [CNT_W-1:0]    cnt    [2];
    logic [GLITCH_W-1:0] glitch [2];
    logic [1:0]          rise;
    logic [1:0]          fall;

    assign raw = {raw_b, raw_a};

    // Two-flop synchronizer for both raw inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Per-channel debounce FSM: qualify a new level for STABLE_CNT samples, count aborted attempts.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                st[i]     <= STABLE_LO;
                cnt[i]    <= '0;
                glitch[i] <= '0;
            end
            rise <= '0;
            fall <= '0;
        end else begin
            rise <= '0;
            fall <= '0;
            for (int i = 0; i < 2; i++) begin
                case (st[i])
                    STABLE_LO: begin
                        if (s2[i]) begin
                            st[i]  <= WAIT_HI;
                            cnt[i] <= CNT_W'(1);
                        end
                    end
                    WAIT_HI: begin
                        if (!s2[i]) begin
                            st[i]  <= STABLE_LO;
                            cnt[i] <= '0;
                            if (glitch[i] != '1) glitch[i] <= glitch[i] + GLITCH_W'(1);
                        end else if (cnt[i] == CNT_LAST) begin
                            st[i]   <= STABLE_HI;
                            cnt[i]  <= '0;
                            rise[i] <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                    STABLE_HI: begin
                        if (!s2[i]) begin
                            st[i]  <= WAIT_LO;
                            cnt[i] <= CNT_W'(1);
                        end
                    end
                    WAIT_LO: begin
                        if (s2[i]) begin
                            st[i]  <= STABLE_HI;
                            cnt[i] <= '0;
                            if (glitch[i] != '1) glitch[i] <= glitch[i] + GLITCH_W'(1);
                        end else if (cnt[i] == CNT_LAST) begin
                            st[i]   <= STABLE_LO;
                            cnt[i]  <= '0;
                            fall[i] <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        st[i]  <= STABLE_LO;
                        cnt[i] <= '0;
                    end
                endcase
            end
        end
    end

    // Level is high while settled high or while a fall is still qualifying.
    assign a = (st[0] == STABLE_HI) || (st[0] == WAIT_LO);
    assign b = (st[1] == STABLE_HI) || (st[1] == WAIT_LO);

    assign a_rise = rise[0];
    assign a_fall = fall[0];
    assign b_rise = rise[1];
    assign b_fall = fall[1];

    assign ab_stable = (st[0] == STABLE_LO || st[0] == STABLE_HI) &&
                       (st[1] == STABLE_LO || st[1] == STABLE_HI);

    assign a_glitches = glitch[0];
    assign b_glitches = glitch[1];

endmodule

// File: tb/tb_ab_input_conditioner.sv
// Purpose: self-checking bench for ab_input_conditioner against a run-length debounce model.
// Latency: model and DUT are compared 1 time unit after every rising edge.
// Backpressure: not applicable; stimulus is applied every cycle.
module tb_ab_input_conditioner;

    localparam int SC   = 4;
    localparam int CW   = 4;
    localparam int GW   = 8;
    localparam int GMAX = (1 << GW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          raw_a = 1'b0;
    logic          raw_b = 1'b0;
    logic          a, b, a_rise, a_fall, b_rise, b_fall, ab_stable;
    logic [GW-1:0] a_glitches, b_glitches;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    // Reference model: two-sample delay line, then a run length of samples disagreeing with the output.
    int m_s1 [2];
    int m_s2 [2];
    int m_out[2];
    int m_run[2];
    int m_gl [2];
    int m_rise[2];
    int m_fall[2];

    ab_input_conditioner #(.STABLE_CNT(SC), .CNT_W(CW), .GLITCH_W(GW)) dut (
        .clk(clk), .rst(rst), .raw_a(raw_a), .raw_b(raw_b),
        .a(a), .b(b), .a_rise(a_rise), .a_fall(a_fall), .b_rise(b_rise), .b_fall(b_fall),
        .ab_stable(ab_stable), .a_glitches(a_glitches), .b_glitches(b_glitches)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    endtask

    task automatic model_step(input logic r, input logic ra, input logic rb);
        int raw_now[2];
        raw_now[0] = int'(ra);
        raw_now[1] = int'(rb);
        for (int c = 0; c < 2; c++) begin
            m_rise[c] = 0;
            m_fall[c] = 0;
            if (r) begin
                m_s1[c] = 0; m_s2[c] = 0; m_out[c] = 0; m_run[c] = 0; m_gl[c] = 0;
            end else begin
                if (m_s2[c] != m_out[c]) begin
                    m_run[c]++;
                    if (m_run[c] == SC) begin
                        m_out[c] = m_s2[c];
                        m_run[c] = 0;
                        if (m_out[c] == 1) m_rise[c] = 1; else m_fall[c] = 1;
                    end
                end else if (m_run[c] > 0) begin
                    m_run[c] = 0;
                    if (m_gl[c] < GMAX) m_gl[c]++;
                end
                m_s2[c] = m_s1[c];
                m_s1[c] = raw_now[c];
            end
        end
    endtask

    task automatic check_all();
        chk("a",          a,          m_out[0]);
        chk("b",          b,          m_out[1]);
        chk("a_rise",     a_rise,     m_rise[0]);
        chk("a_fall",     a_fall,     m_fall[0]);
        chk("b_rise",     b_rise,     m_rise[1]);
        chk("b_fall",     b_fall,     m_fall[1]);
        chk("ab_stable",  ab_stable,  (m_run[0] == 0 && m_run[1] == 0) ? 1 : 0);
        chk("a_glitches", a_glitches, m_gl[0]);
        chk("b_glitches", b_glitches, m_gl[1]);
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic tick(input logic r, input logic ra, input logic rb);
        rst   = r;
        raw_a = ra;
        raw_b = rb;
        @(posedge clk);
        cyc++;
        model_step(r, ra, rb);
        #1;
        check_all();
    endtask

    // Hold raw_a at lvl for 20 edges; report the 1-based edge where a first equals lvl and pulse count.
    task automatic measure_a(input logic lvl, output int edge_no, output int pulses);
        edge_no = 0;
        pulses  = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1'b0, lvl, raw_b);
            if (a_rise === 1'b1 || a_fall === 1'b1) pulses++;
            if (a === lvl && edge_no == 0) edge_no = i;
        end
    endtask

    initial begin
        int e, p, ea, eb, nb;
        for (int c = 0; c < 2; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_out[c] = 0; m_run[c] = 0; m_gl[c] = 0;
            m_rise[c] = 0; m_fall[c] = 0;
        end

        // 1. Reset values with raw inputs high, then first qualification after release.
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        chk("rst_a", a, 0);
        chk("rst_b", b, 0);
        chk("rst_pulses", {a_rise, a_fall, b_rise, b_fall}, 0);
        chk("rst_ab_stable", ab_stable, 1);
        chk("rst_glitches", {a_glitches, b_glitches}, 0);
        measure_a(1'b1, e, p);
        chk("post_rst_rise_edge", e, SC + 2);
        chk("post_rst_rise_pulses", p, 1);
        measure_a(1'b0, e, p);
        raw_b = 1'b0;
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0);

        // 2. Clean rise then fall on A.
        measure_a(1'b1, e, p);
        chk("clean_rise_edge", e, SC + 2);
        chk("clean_rise_pulses", p, 1);
        measure_a(1'b0, e, p);
        chk("clean_fall_edge", e, SC + 2);
        chk("clean_fall_pulses", p, 1);

        // 3. Three short pulses on B are rejected.
        nb = 0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 2; i++) begin tick(1'b0, 1'b0, 1'b1); if (b_rise === 1'b1) nb++; end
            for (int i = 0; i < 4; i++) begin tick(1'b0, 1'b0, 1'b0); if (b_rise === 1'b1) nb++; end
        end
        chk("glitch_b_level", b, 0);
        chk("glitch_b_rises", nb, 0);
        chk("glitch_b_count", b_glitches, 3);

        // 5. Both channels rise together.
        ea = 0;
        eb = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(1'b0, 1'b1, 1'b1);
            if (a_rise === 1'b1 && ea == 0) ea = i;
            if (b_rise === 1'b1 && eb == 0) eb = i;
        end
        chk("simul_a_rise_edge", ea, SC + 2);
        chk("simul_b_rise_edge", eb, SC + 2);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0);

        // 4. 300 short glitches on A saturate the counter and it stays there.
        for (int k = 0; k < 300; k++) begin
            tick(1'b0, 1'b1, 1'b0);
            tick(1'b0, 1'b0, 1'b0);
            tick(1'b0, 1'b0, 1'b0);
            tick(1'b0, 1'b0, 1'b0);
        end
        chk("sat_a_glitches", a_glitches, GMAX);
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 1'b1, 1'b0);
            tick(1'b0, 1'b0, 1'b0);
            tick(1'b0, 1'b0, 1'b0);
        end
        chk("sat_hold_a_glitches", a_glitches, GMAX);
        chk("sat_a_level", a, 0);

        // 6. Reset at E3 in the middle of a qualification.
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        chk("midrst_a", a, 0);
        chk("midrst_a_rise", a_rise, 0);
        measure_a(1'b1, e, p);
        chk("midrst_rise_edge", e, SC + 2);
        chk("midrst_rise_pulses", p, 1);
        chk("midrst_a_glitches", a_glitches, 0);

        // Random segments of held levels on both channels.
        tick(1'b1, 1'b0, 1'b0);
        begin
            logic la, lb;
            int   ha, hb;
            la = 1'b0; lb = 1'b0; ha = 0; hb = 0;
            for (int i = 0; i < 1500; i++) begin
                if (ha == 0) begin la = ~la; ha = $urandom_range(1, 8); end
                if (hb == 0) begin lb = ~lb; hb = $urandom_range(1, 8); end
                ha--; hb--;
                tick(($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0, la, lb);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
